multiword_adder: RTL and testbench
==================================

MULTIWORD_ADDER -- requirements
Module: multiword_adder

Interface
REQ-001 SHALL have parameter CHUNK, default 32: bit width of one adder slice, power of two, at least 4.
REQ-002 SHALL have parameter WORDS, default 4: number of slices per operand, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: operands present.
REQ-006 SHALL have port in_ready, output, 1: block accepts operands.
REQ-007 SHALL have port a, input, CHUNK*WORDS: first operand.
REQ-008 SHALL have port b, input, CHUNK*WORDS: second operand.
REQ-009 SHALL have port cin, input, 1: carry-in; ignored when sub=1.
REQ-010 SHALL have port sub, input, 1: 1 selects a-b, 0 selects a+b+cin.
REQ-011 SHALL have port out_valid, output, 1: result present.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port sum, output, CHUNK*WORDS: result.
REQ-014 SHALL have port cout, output, 1: carry out of the top slice; for sub=1, cout=1 means no borrow.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 SHALL transition IDLE->RUN on in_valid&&in_ready, capturing a, b, sub and the initial carry (sub ? 1 : cin), and loading slice index 0.
REQ-017 SHALL assert in_ready only in IDLE, so a transfer occurs on in_valid&&in_ready.
REQ-018 SHALL, each RUN cycle, add slice k of a, slice k of b (inverted when sub=1) and the carry register, all through one CHUNK-wide adder.
REQ-019 SHALL, each RUN cycle, write the slice result into sum slice k, store the adder carry-out in the carry register, and increment k.
REQ-020 SHALL transition RUN->DONE in the cycle slice WORDS-1 is written; the final carry becomes cout.
REQ-021 SHALL assert out_valid in DONE; sum and cout stay stable while out_valid=1 and out_ready=0.
REQ-022 SHALL transition DONE->IDLE on out_valid&&out_ready.
REQ-023 SHALL give a latency of exactly WORDS+1 cycles from the input handshake edge to the first out_valid=1 cycle.
REQ-024 SHALL give a throughput of one operation per WORDS+2 cycles under continuous valid/ready.
REQ-025 SHALL ignore in_valid and input operand changes outside IDLE, taking operands only from the captured registers.
REQ-026 SHALL wrap modulo 2^(CHUNK*WORDS) with no saturation: all-ones plus 1 gives sum=0, cout=1.
REQ-027 SHALL hold the slice counter ceil(log2(WORDS)) bits wide and never index past WORDS-1.

Reset
REQ-028 SHALL, on rst=1 and regardless of clk, set state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, the carry register to 0 and k=0.
REQ-029 SHALL abort any operation when rst asserts mid-RUN or in DONE; no partial result is ever presented.
REQ-030 SHALL allow the first handshake on the first rising clk edge after rst deasserts.

Configuration
REQ-031 SHALL support macro MULTIWORD_ADDER_OVERFLOW_EN.
REQ-032 SHALL, when MULTIWORD_ADDER_OVERFLOW_EN is defined, add output port ovf (1 bit): two's-complement signed overflow of the full-width operation.
REQ-033 SHALL compute ovf as the XOR of the carry into and the carry out of the top bit of slice WORDS-1, valid with out_valid and reset to 0.
REQ-034 SHALL, when MULTIWORD_ADDER_OVERFLOW_EN is undefined, have no ovf port and no related logic; all other behaviour is identical.

Structure
REQ-035 SHALL place in shared package multiword_adder_pkg the FSM state enum (IDLE, RUN, DONE) and the default CHUNK and WORDS constants.
REQ-036 SHALL instantiate exactly one sub-module, the existing parallel-prefix adder PrefixAdder with WIDTH=CHUNK, sub tied to 0 and cin driven from the carry register.

Verification
REQ-037 SHALL verify, with CHUNK=8 and WORDS=4: a=0x000000FF, b=0x00000001, cin=0, sub=0 -> out_valid on cycle 5 after the handshake, sum=0x00000100, cout=0.
REQ-038 SHALL verify a=0xFFFFFFFF, b=0x00000000, cin=1, sub=0 -> sum=0x00000000, cout=1, carry ripples through all 4 slices.
REQ-039 SHALL verify a=0x00000005, b=0x00000007, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0; with the macro defined, ovf=0.
REQ-040 SHALL verify a=0x7FFFFFFF, b=0x00000001, sub=0 with the macro defined -> sum=0x80000000, ovf=1.
REQ-041 SHALL verify that holding out_ready=0 for 10 cycles in DONE keeps sum/cout stable and in_ready=0, and that in_valid pulses during RUN are not accepted.
REQ-042 SHALL verify that rst pulsed in the RUN cycle of slice 2 gives out_valid=0, in_ready=1 and sum=0 asynchronously, and that the next operation returns a correct result.

Source files
------------

// File: rtl/multiword_adder_pkg.sv
// multiword_adder_pkg: shared FSM state type and default slice geometry
package multiword_adder_pkg;
  localparam int CHUNK_DEF = 32;
  localparam int WORDS_DEF = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/multiword_adder_if.sv
// multiword_adder_if: operand/result handshake bus; ovf exists only with MULTIWORD_ADDER_OVERFLOW_EN
interface multiword_adder_if import multiword_adder_pkg::*; #(
  parameter int CHUNK = CHUNK_DEF,
  parameter int WORDS = WORDS_DEF
);
  logic in_valid;
  logic in_ready;
  logic [CHUNK*WORDS-1:0] a;
  logic [CHUNK*WORDS-1:0] b;
  logic cin;
  logic sub;
  logic out_valid;
  logic out_ready;
  logic [CHUNK*WORDS-1:0] sum;
  logic cout;
`ifdef MULTIWORD_ADDER_OVERFLOW_EN
  logic ovf;
  modport master (output in_valid, a, b, cin, sub, out_ready, input in_ready, out_valid, sum, cout, ovf);
  modport slave (input in_valid, a, b, cin, sub, out_ready, output in_ready, out_valid, sum, cout, ovf);
`else
  modport master (output in_valid, a, b, cin, sub, out_ready, input in_ready, out_valid, sum, cout);
  modport slave (input in_valid, a, b, cin, sub, out_ready, output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/multiword_adder_prefix.sv
// PrefixAdder: Kogge-Stone parallel-prefix adder with optional subtract
module PrefixAdder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int L = $clog2(WIDTH);
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] pr;
  logic c0;
  assign bx = b ^ {WIDTH{sub}};
  assign pr = a ^ bx;
  assign c0 = cin | sub;
  for (genvar l = 0; l <= L; l++) begin : lv
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    if (l == 0) begin : s0
      // carry-in folded into bit 0 generate so the prefix tree yields carries directly
      assign g = (a & bx) | {{(WIDTH-1){1'b0}}, pr[0] & c0};
      assign p = pr;
    end else begin : sn
      for (genvar i = 0; i < WIDTH; i++) begin : bt
        if (i >= (1 << (l - 1))) begin : mg
          assign g[i] = lv[l-1].g[i] | (lv[l-1].p[i] & lv[l-1].g[i-(1<<(l-1))]);
          assign p[i] = lv[l-1].p[i] & lv[l-1].p[i-(1<<(l-1))];
        end else begin : ps
          assign g[i] = lv[l-1].g[i];
          assign p[i] = lv[l-1].p[i];
        end
      end
    end
  end
  assign sum = pr ^ {lv[L].g[WIDTH-2:0], c0};
  assign cout = lv[L].g[WIDTH-1];
endmodule

// File: rtl/multiword_adder.sv
// multiword_adder: slice-serial wide add/sub over one CHUNK adder; MULTIWORD_ADDER_OVERFLOW_EN adds ovf
module multiword_adder import multiword_adder_pkg::*; #(
  parameter int CHUNK = CHUNK_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input logic clk,
  input logic rst,
  multiword_adder_if.slave bus
);
  localparam int KW = $clog2(WORDS);
  state_t state;
  logic [KW-1:0] k;
  logic [WORDS-1:0][CHUNK-1:0] ra;
  logic [WORDS-1:0][CHUNK-1:0] rb;
  logic [WORDS-1:0][CHUNK-1:0] rs;
  logic carry;
  logic cout_r;
  logic [CHUNK-1:0] s;
  logic co;
  logic last;
  assign last = k == KW'(WORDS - 1);
  PrefixAdder #(.WIDTH(CHUNK)) u_add (
    .a(ra[k]),
    .b(rb[k]),
    .cin(carry),
    .sub(1'b0),
    .sum(s),
    .cout(co)
  );
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.sum = rs;
  assign bus.cout = cout_r;
`ifdef MULTIWORD_ADDER_OVERFLOW_EN
  logic ovf_r;
  logic ctop;
  assign ctop = ra[k][CHUNK-1] ^ rb[k][CHUNK-1] ^ s[CHUNK-1];
  assign bus.ovf = ovf_r;
  // signed overflow latched alongside the final slice
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf_r <= 1'b0;
    else if (state == RUN && last) ovf_r <= ctop ^ co;
`endif
  // capture operands (b pre-inverted for subtract), walk slices, hold result until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      ra <= '0;
      rb <= '0;
      rs <= '0;
      carry <= 1'b0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          ra <= bus.a;
          rb <= bus.sub ? ~bus.b : bus.b;
          carry <= bus.sub | bus.cin;
          k <= '0;
          state <= RUN;
        end
        RUN: begin
          rs[k] <= s;
          carry <= co;
          k <= last ? '0 : k + 1'b1;
          if (last) begin
            cout_r <= co;
            state <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multiword_adder.sv
// tb_multiword_adder: randomized and directed checks of multiword_adder (CHUNK=8, WORDS=4)
module tb_multiword_adder;
  localparam int CHUNK = 8;
  localparam int WORDS = 4;
  localparam int W = CHUNK * WORDS;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  multiword_adder_if #(.CHUNK(CHUNK), .WORDS(WORDS)) bus ();
  multiword_adder #(.CHUNK(CHUNK), .WORDS(WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  // {ovf, cout, sum} from plain integer arithmetic on the full-width operands
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    longint sa, sb, sr;
    logic [W:0] u;
    logic v;
    sa = $signed(a);
    sb = $signed(b);
    sr = s ? sa - sb : sa + sb + longint'(c);
    v = sr > 64'sd2147483647 || sr < -64'sd2147483648;
    u = s ? {a >= b, a - b} : {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    return {v, u};
  endfunction
  // call right after a negedge; returns at a negedge with the block back in IDLE
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s, input int hold, input string tag, input bit pulse);
    logic [W+1:0] e;
    int n;
    e = model(a, b, c, s);
    bus.a = a;
    bus.b = b;
    bus.cin = c;
    bus.sub = s;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    check({tag, ".ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    bus.in_valid = pulse;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.cin = ~c;
    bus.sub = ~s;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check({tag, ".latency"}, 64'(n), 64'(WORDS + 1));
    check({tag, ".result"}, 64'({bus.cout, bus.sum}), 64'(e[W:0]));
`ifdef MULTIWORD_ADDER_OVERFLOW_EN
    check({tag, ".ovf"}, 64'(bus.ovf), 64'(e[W+1]));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = 1'(i & 1);
      check({tag, ".hold"}, 64'({bus.out_valid, bus.in_ready, bus.cout, bus.sum}), 64'({2'b10, e[W:0]}));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, ".idle"}, 64'({bus.in_ready, bus.out_valid}), 64'd2);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", 64'({bus.in_ready, bus.out_valid, bus.cout, bus.sum}), 64'({2'b10, 33'd0}));
`ifdef MULTIWORD_ADDER_OVERFLOW_EN
    check("reset.ovf", 64'(bus.ovf), 64'd0);
`endif
    rst = 1'b0;
    do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0, "carry8", 1'b0);
    do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 0, "ripple", 1'b0);
    do_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 0, "sub", 1'b0);
    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, "sovf", 1'b0);
    do_op(32'h12345678, 32'h12345678, 1'b0, 1'b1, 0, "subeq", 1'b0);
    do_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 0, "subovf", 1'b0);
    do_op(32'hDEADBEEF, 32'h01020304, 1'b1, 1'b0, 10, "stall", 1'b1);
    bus.a = 32'hAAAAAAAA;
    bus.b = 32'h55555555;
    bus.cin = 1'b1;
    bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort", 64'({bus.out_valid, bus.in_ready, bus.sum}), 64'({2'b01, 32'd0}));
    @(negedge clk);
    rst = 1'b0;
    do_op(32'h0F0F0F0F, 32'hF0F0F0F1, 1'b0, 1'b0, 0, "after_rst", 1'b0);
    for (int i = 0; i < 24; i++)
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2), "rnd", 1'(i & 1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
